// File: rtl/bp_fe_btb_wr_sched_pkg.sv
// Shared types for the FE BTB write scheduler: sequencer state and the write request layout.
`define BP_FE_BTB_WR_REQ_DECLARE(vaddr_w, tag_w, idx_w) \
  typedef struct packed { \
    logic clr; \
    logic jmp; \
    logic [tag_w-1:0] tag; \
    logic [idx_w-1:0] idx; \
    logic [vaddr_w-1:0] tgt; \
  } bp_fe_btb_wr_req_s

package bp_fe_btb_wr_sched_pkg;

  typedef enum logic [0:0] {
    e_run   = 1'b0,
    e_flush = 1'b1
  } bp_fe_btb_sched_state_e;

endpackage

// File: rtl/bp_fe_btb_wr_sched_arb.sv
// Fixed-priority 2:1 select of FIFO heads onto the BTB write port; the loser holds its head.
module bp_fe_btb_wr_sched_arb #(
  parameter int width_p = 1
) (
  input  logic               en_i,
  input  logic               hi_v_i,
  input  logic [width_p-1:0] hi_data_i,
  input  logic               lo_v_i,
  input  logic [width_p-1:0] lo_data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               hi_deq_o,
  output logic               lo_deq_o
);

  always_comb begin
    hi_deq_o = en_i & hi_v_i;
    lo_deq_o = en_i & ~hi_v_i & lo_v_i;
    v_o      = hi_deq_o | lo_deq_o;
    data_o   = '0;
    if (hi_deq_o) begin
      data_o = hi_data_i;
    end else if (lo_deq_o) begin
      data_o = lo_data_i;
    end
  end

endmodule

// File: rtl/bp_fe_btb_wr_sched.sv
// BTB write scheduler: buffers redirect / FE-correction updates, issues one write per cycle,
// sequences full-table clear sweeps and flags reads that race a same-index write.
module bp_fe_btb_wr_sched
  import bp_fe_btb_wr_sched_pkg::*;
#(
  parameter int vaddr_width_p   = 39,
  parameter int btb_tag_width_p = 10,
  parameter int btb_idx_width_p = 6,
  parameter int fifo_els_p      = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       rd_v_i,
  output logic                       rd_ready_o,
  input  logic                       rd_clr_i,
  input  logic                       rd_jmp_i,
  input  logic [btb_tag_width_p-1:0] rd_tag_i,
  input  logic [btb_idx_width_p-1:0] rd_idx_i,
  input  logic [vaddr_width_p-1:0]   rd_tgt_i,
  input  logic                       fe_v_i,
  output logic                       fe_ready_o,
  input  logic                       fe_clr_i,
  input  logic                       fe_jmp_i,
  input  logic [btb_tag_width_p-1:0] fe_tag_i,
  input  logic [btb_idx_width_p-1:0] fe_idx_i,
  input  logic [vaddr_width_p-1:0]   fe_tgt_i,
  input  logic                       flush_v_i,
  output logic                       flush_ready_o,
  output logic                       flush_done_o,
  input  logic                       r_v_i,
  input  logic [btb_idx_width_p-1:0] r_idx_i,
  output logic                       r_v_o,
  output logic                       r_kill_o,
  output logic                       w_v_o,
  output logic                       w_clr_o,
  output logic                       w_jmp_o,
  output logic [btb_tag_width_p-1:0] w_tag_o,
  output logic [btb_idx_width_p-1:0] w_idx_o,
  output logic [vaddr_width_p-1:0]   w_tgt_o,
  output logic                       busy_o,
  output bp_fe_btb_sched_state_e     state_o
);

  `BP_FE_BTB_WR_REQ_DECLARE(vaddr_width_p, btb_tag_width_p, btb_idx_width_p);

  localparam int req_width_lp = $bits(bp_fe_btb_wr_req_s);
  localparam int ptr_width_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_width_lp = $clog2(fifo_els_p + 1);
  localparam logic [btb_idx_width_p:0] sweep_last_lp = (btb_idx_width_p+1)'((1 << btb_idx_width_p) - 1);

  // Handshakes (both update sources and flush): a transfer happens in any cycle where
  // valid and ready are both high at the clock edge; ready never depends on the same-cycle valid
  // of that source, only on flush_v_i, which takes precedence over updates.

  bp_fe_btb_sched_state_e state_q, state_n;
  logic is_run, is_flush, flush_hs;
  logic [btb_idx_width_p:0] sweep_q;
  logic sweep_last;

  logic [1:0] enq_v, deq, empty, full;
  bp_fe_btb_wr_req_s [1:0] enq_req, head_req;
  logic arb_v;
  logic [req_width_lp-1:0] arb_data;
  bp_fe_btb_wr_req_s w_req;

  assign is_run     = (state_q == e_run);
  assign is_flush   = (state_q == e_flush);
  assign flush_hs   = flush_v_i & is_run;
  assign sweep_last = (sweep_q == sweep_last_lp);
  assign state_o    = state_q;

  assign enq_req[0] = '{clr: rd_clr_i, jmp: rd_jmp_i, tag: rd_tag_i, idx: rd_idx_i, tgt: rd_tgt_i};
  assign enq_req[1] = '{clr: fe_clr_i, jmp: fe_jmp_i, tag: fe_tag_i, idx: fe_idx_i, tgt: fe_tgt_i};

  assign rd_ready_o = is_run & ~flush_v_i & ~full[0];
  assign fe_ready_o = is_run & ~flush_v_i & ~full[1];
  assign enq_v[0]   = rd_v_i & rd_ready_o;
  assign enq_v[1]   = fe_v_i & fe_ready_o;

  // Per-source FIFOs; a flush handshake purges both because their contents are stale.
  for (genvar s = 0; s < 2; s++) begin : g_fifo
    bp_fe_btb_wr_req_s mem_q [fifo_els_p];
    logic [ptr_width_lp-1:0] rptr_q, wptr_q;
    logic [cnt_width_lp-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (enq_v[s]) begin
        mem_q[wptr_q] <= enq_req[s];
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i | flush_hs) begin
        rptr_q <= '0;
        wptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (enq_v[s]) begin
          wptr_q <= (wptr_q == ptr_width_lp'(fifo_els_p - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (deq[s]) begin
          rptr_q <= (rptr_q == ptr_width_lp'(fifo_els_p - 1)) ? '0 : rptr_q + 1'b1;
        end
        cnt_q <= cnt_q + cnt_width_lp'(enq_v[s]) - cnt_width_lp'(deq[s]);
      end
    end

    assign empty[s]    = (cnt_q == '0);
    assign full[s]     = (cnt_q == cnt_width_lp'(fifo_els_p));
    assign head_req[s] = mem_q[rptr_q];
  end

  bp_fe_btb_wr_sched_arb #(.width_p(req_width_lp)) arb (
    .en_i      (is_run & ~flush_v_i),
    .hi_v_i    (~empty[0]),
    .hi_data_i (head_req[0]),
    .lo_v_i    (~empty[1]),
    .lo_data_i (head_req[1]),
    .v_o       (arb_v),
    .data_o    (arb_data),
    .hi_deq_o  (deq[0]),
    .lo_deq_o  (deq[1])
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_run;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      e_run:   if (flush_hs)   state_n = e_flush;
      e_flush: if (sweep_last) state_n = e_run;
      default: state_n = e_run;
    endcase
  end

  always_comb begin
    w_v_o         = 1'b0;
    w_req         = '0;
    flush_done_o  = 1'b0;
    flush_ready_o = 1'b0;
    unique case (state_q)
      e_run: begin
        flush_ready_o = 1'b1;
        w_v_o         = arb_v;
        w_req         = bp_fe_btb_wr_req_s'(arb_data);
      end
      e_flush: begin
        w_v_o        = 1'b1;
        w_req.clr    = 1'b1;
        w_req.idx    = sweep_q[btb_idx_width_p-1:0];
        flush_done_o = sweep_last;
      end
      default: ;
    endcase
  end

  assign w_clr_o = w_req.clr;
  assign w_jmp_o = w_req.jmp;
  assign w_tag_o = w_req.tag;
  assign w_idx_o = w_req.idx;
  assign w_tgt_o = w_req.tgt;

  // Sweep index restarts on every flush handshake and stops advancing at the last entry.
  always_ff @(posedge clk_i) begin
    if (reset_i | flush_hs) begin
      sweep_q <= '0;
    end else if (is_flush & ~sweep_last) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end

  assign r_v_o = r_v_i & ~is_flush;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_kill_o <= 1'b0;
    end else begin
      r_kill_o <= r_v_i & (is_flush | (w_v_o & (w_idx_o == r_idx_i)));
    end
  end

  assign busy_o = is_flush | ~empty[0] | ~empty[1];

endmodule

// File: tb/tb_bp_fe_btb_wr_sched.sv
// Randomized bench for bp_fe_btb_wr_sched against a queue-based reference model.
module tb_bp_fe_btb_wr_sched;
  import bp_fe_btb_wr_sched_pkg::*;

  localparam int ELS     = 2;
  localparam int ENTRIES = 64;

  typedef struct packed {
    logic        clr;
    logic        jmp;
    logic [9:0]  tag;
    logic [5:0]  idx;
    logic [38:0] tgt;
  } req_t;

  typedef struct {
    bit         rst;
    bit         fl;
    bit         rdv;
    bit         fev;
    bit         rv;
    req_t       rdr;
    req_t       fer;
    logic [5:0] ridx;
  } stim_t;

  logic clk_i = 1'b0;
  logic reset_i, rd_v_i, rd_ready_o, rd_clr_i, rd_jmp_i;
  logic [9:0] rd_tag_i;
  logic [5:0] rd_idx_i;
  logic [38:0] rd_tgt_i;
  logic fe_v_i, fe_ready_o, fe_clr_i, fe_jmp_i;
  logic [9:0] fe_tag_i;
  logic [5:0] fe_idx_i;
  logic [38:0] fe_tgt_i;
  logic flush_v_i, flush_ready_o, flush_done_o;
  logic r_v_i, r_v_o, r_kill_o;
  logic [5:0] r_idx_i;
  logic w_v_o, w_clr_o, w_jmp_o;
  logic [9:0] w_tag_o;
  logic [5:0] w_idx_o;
  logic [38:0] w_tgt_o;
  logic busy_o;
  bp_fe_btb_sched_state_e state_o;

  always #5 clk_i = ~clk_i;

  bp_fe_btb_wr_sched #(
    .vaddr_width_p(39), .btb_tag_width_p(10), .btb_idx_width_p(6), .fifo_els_p(ELS)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .rd_v_i(rd_v_i), .rd_ready_o(rd_ready_o), .rd_clr_i(rd_clr_i), .rd_jmp_i(rd_jmp_i),
    .rd_tag_i(rd_tag_i), .rd_idx_i(rd_idx_i), .rd_tgt_i(rd_tgt_i),
    .fe_v_i(fe_v_i), .fe_ready_o(fe_ready_o), .fe_clr_i(fe_clr_i), .fe_jmp_i(fe_jmp_i),
    .fe_tag_i(fe_tag_i), .fe_idx_i(fe_idx_i), .fe_tgt_i(fe_tgt_i),
    .flush_v_i(flush_v_i), .flush_ready_o(flush_ready_o), .flush_done_o(flush_done_o),
    .r_v_i(r_v_i), .r_idx_i(r_idx_i), .r_v_o(r_v_o), .r_kill_o(r_kill_o),
    .w_v_o(w_v_o), .w_clr_o(w_clr_o), .w_jmp_o(w_jmp_o), .w_tag_o(w_tag_o),
    .w_idx_o(w_idx_o), .w_tgt_o(w_tgt_o), .busy_o(busy_o), .state_o(state_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: queues per source, flush mode and sweep position, pending kill.
  req_t rd_q[$];
  req_t fe_q[$];
  bit   m_flush = 0;
  int   m_sweep = 0;
  bit   m_kill  = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.fl = 0; s.rdv = 0; s.fev = 0; s.rv = 0;
    s.rdr = '0; s.fer = '0; s.ridx = '0;
    return s;
  endfunction

  function automatic req_t rand_req(input int idx_max);
    req_t r;
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    r.clr = 1'($urandom_range(0, 1));
    r.jmp = 1'($urandom_range(0, 1));
    r.tag = 10'($urandom_range(0, 1023));
    r.idx = 6'($urandom_range(0, idx_max));
    r.tgt = t[38:0];
    return r;
  endfunction

  task automatic cycle(input stim_t s);
    bit   run, e_rd_rdy, e_fe_rdy, e_wv, e_done, from_rd, from_fe;
    req_t e_w;
    @(negedge clk_i);
    reset_i   = s.rst;
    flush_v_i = s.fl;
    rd_v_i = s.rdv; rd_clr_i = s.rdr.clr; rd_jmp_i = s.rdr.jmp;
    rd_tag_i = s.rdr.tag; rd_idx_i = s.rdr.idx; rd_tgt_i = s.rdr.tgt;
    fe_v_i = s.fev; fe_clr_i = s.fer.clr; fe_jmp_i = s.fer.jmp;
    fe_tag_i = s.fer.tag; fe_idx_i = s.fer.idx; fe_tgt_i = s.fer.tgt;
    r_v_i = s.rv; r_idx_i = s.ridx;
    #1;
    run      = !m_flush;
    e_rd_rdy = run && !s.fl && (rd_q.size() < ELS);
    e_fe_rdy = run && !s.fl && (fe_q.size() < ELS);
    e_wv = 0; e_done = 0; e_w = '0; from_rd = 0; from_fe = 0;
    if (m_flush) begin
      e_wv = 1; e_w.clr = 1; e_w.idx = 6'(m_sweep); e_done = (m_sweep == ENTRIES - 1);
    end else if (!s.fl && rd_q.size() > 0) begin
      e_wv = 1; e_w = rd_q[0]; from_rd = 1;
    end else if (!s.fl && fe_q.size() > 0) begin
      e_wv = 1; e_w = fe_q[0]; from_fe = 1;
    end
    check("rd_ready", 64'(rd_ready_o), 64'(e_rd_rdy));
    check("fe_ready", 64'(fe_ready_o), 64'(e_fe_rdy));
    check("flush_ready", 64'(flush_ready_o), 64'(run));
    check("flush_done", 64'(flush_done_o), 64'(e_done));
    check("w_v", 64'(w_v_o), 64'(e_wv));
    check("w_clr", 64'(w_clr_o), 64'(e_w.clr));
    check("w_jmp", 64'(w_jmp_o), 64'(e_w.jmp));
    check("w_tag", 64'(w_tag_o), 64'(e_w.tag));
    check("w_idx", 64'(w_idx_o), 64'(e_w.idx));
    check("w_tgt", 64'(w_tgt_o), 64'(e_w.tgt));
    check("r_v", 64'(r_v_o), 64'(s.rv && run));
    check("r_kill", 64'(r_kill_o), 64'(m_kill));
    check("busy", 64'(busy_o), 64'(m_flush || rd_q.size() > 0 || fe_q.size() > 0));
    @(posedge clk_i);
    if (s.rst) begin
      rd_q.delete(); fe_q.delete();
      m_flush = 0; m_sweep = 0; m_kill = 0;
    end else begin
      m_kill = s.rv && (m_flush || (e_wv && e_w.idx == s.ridx));
      if (run && s.fl) begin
        rd_q.delete(); fe_q.delete();
        m_flush = 1; m_sweep = 0;
      end else if (m_flush) begin
        if (m_sweep == ENTRIES - 1) m_flush = 0;
        else m_sweep++;
      end else begin
        if (from_rd) void'(rd_q.pop_front());
        if (from_fe) void'(fe_q.pop_front());
        if (s.rdv && e_rd_rdy) rd_q.push_back(s.rdr);
        if (s.fev && e_fe_rdy) fe_q.push_back(s.fer);
      end
    end
  endtask

  stim_t s;

  initial begin
    s = idle();
    reset_i = 1; flush_v_i = 0; rd_v_i = 0; fe_v_i = 0; r_v_i = 0; r_idx_i = '0;
    rd_clr_i = 0; rd_jmp_i = 0; rd_tag_i = '0; rd_idx_i = '0; rd_tgt_i = '0;
    fe_clr_i = 0; fe_jmp_i = 0; fe_tag_i = '0; fe_idx_i = '0; fe_tgt_i = '0;
    repeat (2) @(posedge clk_i);

    // Single redirect update, written the following cycle.
    s = idle(); s.rdv = 1;
    s.rdr = '{clr: 1'b0, jmp: 1'b1, tag: 10'h12, idx: 6'd5, tgt: 39'h0080001000};
    cycle(s);
    repeat (2) cycle(idle());

    // Both sources valid for three cycles: redirect wins, FE FIFO fills.
    s = idle(); s.rdv = 1; s.fev = 1;
    s.rdr = rand_req(63); s.rdr.idx = 6'd3;
    s.fer = rand_req(63); s.fer.idx = 6'd4;
    repeat (3) cycle(s);
    repeat (6) cycle(idle());

    // Flush with one entry queued per source.
    s = idle(); s.rdv = 1; s.fev = 1; s.rdr = rand_req(63); s.fer = rand_req(63);
    cycle(s);
    s = idle(); s.fl = 1;
    cycle(s);
    repeat (ENTRIES + 2) cycle(idle());

    // Read/write index collision and near-miss.
    for (int k = 7; k <= 8; k++) begin
      s = idle(); s.rdv = 1; s.rdr = rand_req(63); s.rdr.idx = 6'd7;
      cycle(s);
      s = idle(); s.rv = 1; s.ridx = 6'(k);
      cycle(s);
      cycle(idle());
    end

    // Reset in the middle of a sweep.
    s = idle(); s.fl = 1;
    cycle(s);
    for (int i = 0; i < ENTRIES && m_sweep != 20; i++) cycle(idle());
    s = idle(); s.rst = 1;
    cycle(s);
    repeat (2) cycle(idle());

    // Read held across an entire flush.
    s = idle(); s.fl = 1; s.rv = 1;
    cycle(s);
    s = idle(); s.rv = 1; s.ridx = 6'($urandom_range(0, 63));
    repeat (ENTRIES + 3) cycle(s);

    // Random traffic with a narrow index range to provoke read/write collisions.
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst  = ($urandom_range(0, 499) == 0);
      s.fl   = ($urandom_range(0, 79) == 0);
      s.rdv  = ($urandom_range(0, 99) < 45);
      s.fev  = ($urandom_range(0, 99) < 45);
      s.rv   = ($urandom_range(0, 99) < 60);
      s.rdr  = rand_req(7);
      s.fer  = rand_req(7);
      s.ridx = 6'($urandom_range(0, 7));
      cycle(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
